// File: rtl/mem_arbiter_if.sv
// Bundles the fetch-side, data-side and physical-memory handshake signals of the
// memory arbiter. The arbiter takes the slave view; requesters and memory take master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_resp;

    logic              dmem_read;
    logic              dmem_write;
    logic [ADDR_W-1:0] dmem_address;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  imem_read, imem_address,
        output imem_rdata, imem_resp,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output imem_read, imem_address,
        input  imem_rdata, imem_resp,
        output dmem_read, dmem_write, dmem_address, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between the fetch (read-only) and data (read/write)
// requesters, one latched transaction at a time, with round-robin tie breaking.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_d;
    logic              abort;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant;
    logic pmem_read_c;
    logic pmem_write_c;
    logic imem_resp_c;
    logic dmem_resp_c;

    assign i_req = bus.imem_read;
    assign d_req = bus.dmem_read | bus.dmem_write;
    assign grant = (state == IDLE) && (next_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ties go to whichever side did not win last time, so neither requester starves.
    always_comb begin
        next_state   = state;
        pmem_read_c  = 1'b0;
        pmem_write_c = 1'b0;
        imem_resp_c  = 1'b0;
        dmem_resp_c  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    next_state = last_d ? SERVE_I : SERVE_D;
                end else if (i_req) begin
                    next_state = SERVE_I;
                end else if (d_req) begin
                    next_state = SERVE_D;
                end
            end
            SERVE_I: begin
                pmem_read_c  = ~op_write;
                pmem_write_c = op_write;
                if (bus.pmem_resp) begin
                    imem_resp_c = ~abort;
                    next_state  = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read_c  = ~op_write;
                pmem_write_c = op_write;
                if (bus.pmem_resp) begin
                    dmem_resp_c = ~abort;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The command is captured on the grant edge so requester-side changes during
    // a transaction never reach memory; a simultaneous read+write becomes a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d   <= 1'b0;
            abort    <= 1'b0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (grant) begin
            last_d   <= (next_state == SERVE_D);
            abort    <= 1'b0;
            op_write <= (next_state == SERVE_D) && bus.dmem_write;
            addr_q   <= (next_state == SERVE_D) ? bus.dmem_address : bus.imem_address;
            wdata_q  <= (next_state == SERVE_D) ? bus.dmem_wdata : '0;
        end else if ((state == SERVE_I && !i_req) || (state == SERVE_D && !d_req)) begin
            abort <= 1'b1;
        end
    end

    assign bus.pmem_read    = pmem_read_c;
    assign bus.pmem_write   = pmem_write_c;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.imem_resp    = imem_resp_c;
    assign bus.dmem_resp    = dmem_resp_c;
    assign bus.imem_rdata   = bus.pmem_rdata;
    assign bus.dmem_rdata   = bus.pmem_rdata;
    assign busy             = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected pmem issues and responses
// into queues that a negedge monitor pops and compares.
module tb_mem_arbiter;
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } issue_t;

    typedef struct {
        logic        side_d;
        logic        chk_data;
        logic [15:0] data;
    } resp_t;

    logic clk;
    logic rst_n;
    logic busy;

    int compared;
    int mismatched;

    issue_t issue_q[$];
    resp_t  resp_q[$];

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic i_rd, input logic [15:0] i_addr,
                                  input logic d_rd, input logic d_wr,
                                  input logic [15:0] d_addr, input logic [15:0] d_wdata);
        bus.imem_read    = i_rd;
        bus.imem_address = i_addr;
        bus.dmem_read    = d_rd;
        bus.dmem_write   = d_wr;
        bus.dmem_address = d_addr;
        bus.dmem_wdata   = d_wdata;
    endtask

    task automatic expect_issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        issue_t it;
        it.wr = wr; it.addr = addr; it.wdata = wdata;
        issue_q.push_back(it);
    endtask

    task automatic expect_resp(input logic side_d, input logic chk, input logic [15:0] data);
        resp_t r;
        r.side_d = side_d; r.chk_data = chk; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.pmem_read || bus.pmem_write) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL strobe_timeout: got no pmem strobe required strobe within 20 cycles");
        end
    endtask

    task automatic mem_resp(input logic [15:0] data);
        bus.pmem_rdata = data;
        bus.pmem_resp  = 1'b1;
        tick(1);
        bus.pmem_resp  = 1'b0;
    endtask

    // Monitor: the first strobe cycle of a transaction pops an expected issue, every
    // strobe cycle re-checks the held command, and every resp pulse pops a response.
    issue_t cur;
    bit     in_txn;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
        end else begin
            if (bus.pmem_read || bus.pmem_write) begin
                check_output("one_strobe", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
                if (!in_txn) begin
                    in_txn = 1'b1;
                    if (issue_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_issue: got addr %h required none", bus.pmem_address);
                        cur.wr = bus.pmem_write; cur.addr = bus.pmem_address; cur.wdata = bus.pmem_wdata;
                    end else begin
                        cur = issue_q.pop_front();
                    end
                end
                check_output("issue_op", 32'(bus.pmem_write), 32'(cur.wr));
                check_output("issue_addr", 32'(bus.pmem_address), 32'(cur.addr));
                if (cur.wr) check_output("issue_wdata", 32'(bus.pmem_wdata), 32'(cur.wdata));
                if (bus.pmem_resp) in_txn = 1'b0;
            end
            if (bus.imem_resp || bus.dmem_resp) begin
                check_output("resp_exclusive", 32'(bus.imem_resp & bus.dmem_resp), 32'd0);
                if (resp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_resp: got imem_resp=%0b dmem_resp=%0b required none",
                             bus.imem_resp, bus.dmem_resp);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check_output("resp_side", 32'(bus.dmem_resp), 32'(r.side_d));
                    if (r.chk_data)
                        check_output("resp_rdata", 32'(r.side_d ? bus.dmem_rdata : bus.imem_rdata), 32'(r.data));
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.pmem_rdata = 16'h0;
        bus.pmem_resp  = 1'b0;
        tick(3);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
        check_output("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
        check_output("rst_pmem_address", 32'(bus.pmem_address), 32'd0);
        check_output("rst_resps", 32'({bus.imem_resp, bus.dmem_resp}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] single I read of 0x3000");
        expect_issue(1'b0, 16'h3000, 16'h0);
        expect_resp(1'b0, 1'b1, 16'h1234);
        apply_stimulus(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(1);
        check_output("i_latency_read", 32'(bus.pmem_read), 32'd1);
        check_output("i_latency_addr", 32'(bus.pmem_address), 32'h3000);
        tick(2);
        mem_resp(16'h1234);
        bus.imem_read = 1'b0;
        tick(2);

        $display("[TB] simultaneous I and D, alternation");
        expect_issue(1'b0, 16'h6000, 16'h0); expect_resp(1'b1, 1'b1, 16'hD001);
        expect_issue(1'b0, 16'h3002, 16'h0); expect_resp(1'b0, 1'b1, 16'h1001);
        expect_issue(1'b0, 16'h6000, 16'h0); expect_resp(1'b1, 1'b1, 16'hD002);
        expect_issue(1'b0, 16'h3002, 16'h0); expect_resp(1'b0, 1'b1, 16'h1002);
        apply_stimulus(1'b1, 16'h3002, 1'b1, 1'b0, 16'h6000, 16'h0);
        begin
            logic [15:0] tbl [4];
            tbl[0] = 16'hD001; tbl[1] = 16'h1001; tbl[2] = 16'hD002; tbl[3] = 16'h1002;
            for (int k = 0; k < 4; k++) begin
                wait_strobe();
                mem_resp(tbl[k]);
            end
        end
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(2);

        $display("[TB] D write with address change mid-transaction");
        expect_issue(1'b1, 16'h4000, 16'hBEEF);
        expect_resp(1'b1, 1'b0, 16'h0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h4000, 16'hBEEF);
        wait_strobe();
        tick(1);
        bus.dmem_address = 16'h5000;
        bus.dmem_wdata   = 16'h1111;
        tick(1);
        check_output("wr_held_write", 32'(bus.pmem_write), 32'd1);
        check_output("wr_held_addr", 32'(bus.pmem_address), 32'h4000);
        check_output("wr_held_wdata", 32'(bus.pmem_wdata), 32'hBEEF);
        mem_resp(16'h0);
        bus.dmem_write = 1'b0;
        tick(2);

        $display("[TB] abort: imem_read dropped after grant");
        expect_issue(1'b0, 16'h3010, 16'h0);
        apply_stimulus(1'b1, 16'h3010, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_strobe();
        tick(1);
        bus.imem_read = 1'b0;
        tick(1);
        check_output("abort_read_held", 32'(bus.pmem_read), 32'd1);
        bus.pmem_rdata = 16'hAAAA;
        bus.pmem_resp  = 1'b1;
        #1;
        check_output("abort_no_resp", 32'(bus.imem_resp), 32'd0);
        tick(1);
        bus.pmem_resp = 1'b0;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_idle_read", 32'(bus.pmem_read), 32'd0);
        tick(2);

        $display("[TB] abort then re-raise in same SERVE");
        expect_issue(1'b0, 16'h3020, 16'h0);
        expect_issue(1'b0, 16'h3020, 16'h0);
        expect_resp(1'b0, 1'b1, 16'h5555);
        apply_stimulus(1'b1, 16'h3020, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_strobe();
        tick(1);
        bus.imem_read = 1'b0;
        tick(1);
        bus.imem_read = 1'b1;
        tick(1);
        mem_resp(16'hBBBB);
        wait_strobe();
        mem_resp(16'h5555);
        bus.imem_read = 1'b0;
        tick(2);

        $display("[TB] dmem_read and dmem_write both high");
        expect_issue(1'b1, 16'h4100, 16'hCAFE);
        expect_resp(1'b1, 1'b0, 16'h0);
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h4100, 16'hCAFE);
        wait_strobe();
        tick(1);
        check_output("rw_write", 32'(bus.pmem_write), 32'd1);
        check_output("rw_no_read", 32'(bus.pmem_read), 32'd0);
        mem_resp(16'h0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(2);

        $display("[TB] reset during SERVE_D");
        expect_issue(1'b1, 16'h4200, 16'h0042);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h4200, 16'h0042);
        wait_strobe();
        tick(1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_write", 32'(bus.pmem_write), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        bus.dmem_write = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        bus.pmem_resp = 1'b1;
        #1;
        check_output("stale_resp", 32'({bus.imem_resp, bus.dmem_resp}), 32'd0);
        tick(1);
        bus.pmem_resp = 1'b0;
        expect_issue(1'b0, 16'h6100, 16'h0); expect_resp(1'b1, 1'b1, 16'h7777);
        expect_issue(1'b0, 16'h3030, 16'h0); expect_resp(1'b0, 1'b1, 16'h8888);
        apply_stimulus(1'b1, 16'h3030, 1'b1, 1'b0, 16'h6100, 16'h0);
        wait_strobe();
        mem_resp(16'h7777);
        wait_strobe();
        mem_resp(16'h8888);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(3);

        check_output("issue_q_empty", 32'(issue_q.size()), 32'd0);
        check_output("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
